cache_req_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares a single cache request/response port between `NUM_REQ` requesters. It sits directly in front of the cache under test and allows one transaction in flight at a time. Each accepted request is forwarded to the cache with a valid/ready handshake, and the cache response is routed back to the granted requester. The next grant is then rotated for fairness.

---
 rtl/cache_req_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_cache_req_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter sharing one cache request/response port between NUM_REQ requesters,
// one transaction in flight. Optional response watchdog: define CACHE_ARB_TIMEOUT_EN.
module cache_req_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 64,
    parameter int TIMEOUT_CYC = 1024,
    localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      c_req_valid,
    input  logic                      c_req_ready,
    output logic                      c_req_we,
    output logic [ADDR_W-1:0]         c_req_addr,
    output logic [DATA_W-1:0]         c_req_wdata,
    input  logic                      c_rsp_valid,
    input  logic [DATA_W-1:0]         c_rsp_rdata,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id,
    output logic                      timeout_err,
    output logic [1:0]                dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ID_W-1:0]       r_rr_ptr;
    logic [ID_W-1:0]       r_grant_id;
    logic                  r_c_we;
    logic [ADDR_W-1:0]     r_c_addr;
    logic [DATA_W-1:0]     r_c_wdata;
    logic [NUM_REQ-1:0]    r_rsp_valid;
    logic [DATA_W-1:0]     r_rsp_rdata;

    logic [2*NUM_REQ-1:0]  w_rot;
    logic                  w_found;
    logic [ID_W-1:0]       w_win_id;
    logic [NUM_REQ-1:0]    w_win_oh;
    logic [NUM_REQ-1:0]    w_gnt_oh;
    logic                  w_sel_we;
    logic [ADDR_W-1:0]     w_sel_addr;
    logic [DATA_W-1:0]     w_sel_wdata;
    logic                  w_hs;
    logic                  w_done_ok;
    logic                  w_to_hit;
    logic                  w_finish;
    logic [ID_W-1:0]       w_next_ptr;
    int                    v_sum;

    // Rotate requests so bit 0 is rr_ptr; the lowest set bit wins.
    always_comb begin
        w_rot    = {req_valid, req_valid} >> r_rr_ptr;
        w_found  = 1'b0;
        w_win_id = '0;
        v_sum    = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                v_sum = int'(r_rr_ptr) + k;
                if (v_sum >= NUM_REQ) v_sum = v_sum - NUM_REQ;
                w_found  = 1'b1;
                w_win_id = ID_W'(v_sum);
            end
        end
    end

    always_comb begin
        w_win_oh    = '0;
        w_gnt_oh    = '0;
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_win_oh[j] = (w_win_id == ID_W'(j));
            w_gnt_oh[j] = (r_grant_id == ID_W'(j));
            if (w_win_id == ID_W'(j)) begin
                w_sel_we    = req_we[j];
                w_sel_addr  = req_addr[j*ADDR_W +: ADDR_W];
                w_sel_wdata = req_wdata[j*DATA_W +: DATA_W];
            end
        end
    end

    // Handshakes: a transfer happens in any cycle where valid and ready are both high;
    // requester side uses req_valid/req_ready (ready only in IDLE), cache side c_req_valid/c_req_ready.
    assign w_hs       = (r_state == S_IDLE) && w_found;
    assign w_done_ok  = (r_state == S_WAIT) && c_rsp_valid;
    assign w_finish   = w_done_ok || w_to_hit;
    assign w_next_ptr = (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + ID_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_hs)        w_state_nxt = S_ISSUE;
            S_ISSUE: if (c_req_ready) w_state_nxt = S_WAIT;
            S_WAIT:  if (w_finish)    w_state_nxt = S_IDLE;
            default:                  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_grant_id  <= '0;
            r_c_we      <= 1'b0;
            r_c_addr    <= '0;
            r_c_wdata   <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= '0;
            if (w_hs) begin
                r_c_we     <= w_sel_we;
                r_c_addr   <= w_sel_addr;
                r_c_wdata  <= w_sel_wdata;
                r_grant_id <= w_win_id;
            end
            if (w_finish) begin
                r_rsp_valid <= w_gnt_oh;
                r_rsp_rdata <= w_done_ok ? c_rsp_rdata : '0;
                r_rr_ptr    <= w_next_ptr;
            end
        end
    end

`ifdef CACHE_ARB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout_err;

    // A response in the expiry cycle wins over the watchdog.
    assign w_to_hit = (r_state == S_WAIT) && !c_rsp_valid &&
                      (r_to_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state != S_WAIT)  r_to_cnt <= '0;
            else if (!c_rsp_valid)  r_to_cnt <= r_to_cnt + TO_W'(1);
            if (w_to_hit)           r_timeout_err <= 1'b1;
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_to_hit    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign req_ready   = w_hs ? w_win_oh : '0;
    assign c_req_valid = (r_state == S_ISSUE);
    assign c_req_we    = r_c_we;
    assign c_req_addr  = r_c_addr;
    assign c_req_wdata = r_c_wdata;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rdata   = r_rsp_rdata;
    assign busy        = (r_state != S_IDLE);
    assign grant_id    = r_grant_id;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed bench for cache_req_arbiter: single read, spurious response, backpressure,
// round-robin order, reset mid-WAIT, and the watchdog when CACHE_ARB_TIMEOUT_EN is defined.
module tb_cache_req_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 64;
  localparam int TO_CYC  = 16;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        req_we;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      c_req_valid;
  logic                      c_req_ready;
  logic                      c_req_we;
  logic [ADDR_W-1:0]         c_req_addr;
  logic [DATA_W-1:0]         c_req_wdata;
  logic                      c_rsp_valid;
  logic [DATA_W-1:0]         c_rsp_rdata;
  logic                      busy;
  logic [1:0]                grant_id;
  logic                      timeout_err;
  logic [1:0]                dbg_state;

  int n_total = 0;
  int n_bad   = 0;
  logic [3:0] exp_q[$];

  cache_req_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_we(c_req_we),
    .c_req_addr(c_req_addr), .c_req_wdata(c_req_wdata),
    .c_rsp_valid(c_rsp_valid), .c_rsp_rdata(c_rsp_rdata),
    .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    c_req_ready = 1'b0;
    c_rsp_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_issue(input logic we, input logic [31:0] addr, input logic [63:0] wd);
    chk_eq("iss_valid", c_req_valid, 1);
    chk_eq("iss_addr", c_req_addr, addr);
    chk_eq("iss_we", c_req_we, we);
    chk_eq("iss_wdata", c_req_wdata, wd);
    chk_eq("iss_ready0", req_ready, 0);
  endtask

  // Full transaction: vmask offered in IDLE, id is the expected winner, hold is
  // the req_valid pattern kept up while busy, acc = ISSUE stall cycles, rsp = cycles from accept to response.
  task automatic run_txn(input logic [3:0] vmask, input int id, input logic we,
                         input logic [31:0] addr, input logic [63:0] wd, input int acc,
                         input int rsp, input logic [63:0] rd, input logic [3:0] hold);
    req_we[id] = we;
    req_addr[id*ADDR_W +: ADDR_W] = addr;
    req_wdata[id*DATA_W +: DATA_W] = wd;
    req_valid = vmask;
    #1;
    chk_eq("hs_ready", req_ready, 64'(1) << id);
    step();
    req_valid = hold;
    chk_issue(we, addr, wd);
    chk_eq("grant_id", grant_id, id);
    chk_eq("busy_issue", busy, 1);
    for (int i = 1; i <= acc; i++) begin
      step();
      chk_issue(we, addr, wd);
    end
    c_req_ready = 1'b1;
    step();
    c_req_ready = 1'b0;
    chk_eq("one_forward", c_req_valid, 0);
    chk_eq("busy_wait", busy, 1);
    for (int i = 1; i < rsp; i++) step();
    c_rsp_valid = 1'b1;
    c_rsp_rdata = rd;
    req_valid = '0;
    step();
    c_rsp_valid = 1'b0;
    c_rsp_rdata = {32'($urandom_range(1, 32'hFFFF)), 32'hA5A5_0000};
    chk_eq("rsp_valid", rsp_valid, 64'(1) << id);
    chk_eq("rsp_rdata", rsp_rdata, rd);
    chk_eq("busy_done", busy, 0);
    step();
    chk_eq("rsp_pulse", rsp_valid, 0);
  endtask

  initial begin
    int ncyc;
    logic pend;
    logic [63:0] last_rd;
    logic [3:0] e;

    rst = 1'b1;
    req_we = '0;
    c_req_ready = 1'b0;
    c_rsp_valid = 1'b0;
    c_rsp_rdata = 64'h1111_2222_3333_4444;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_addr[i*ADDR_W +: ADDR_W] = 32'($urandom_range(1, 32'hFFFF));
      req_wdata[i*DATA_W +: DATA_W] = {32'($urandom), 32'($urandom)};
    end
    do_reset();

    // reset values
    chk_eq("rst_ready", req_ready, 0);
    chk_eq("rst_rsp_valid", rsp_valid, 0);
    chk_eq("rst_rsp_rdata", rsp_rdata, 0);
    chk_eq("rst_c_valid", c_req_valid, 0);
    chk_eq("rst_c_we", c_req_we, 0);
    chk_eq("rst_c_addr", c_req_addr, 0);
    chk_eq("rst_c_wdata", c_req_wdata, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_grant", grant_id, 0);
    chk_eq("rst_tmo", timeout_err, 0);

    // single read from requester 2, response 2 cycles after accept
    run_txn(4'b0100, 2, 1'b0, 32'h100, 64'h0, 0, 2, 64'hDEAD_BEEF, 4'b0000);

    // spurious response in IDLE
    c_rsp_valid = 1'b1;
    c_rsp_rdata = 64'h55;
    step();
    c_rsp_valid = 1'b0;
    chk_eq("spur_valid", rsp_valid, 0);
    chk_eq("spur_rdata", rsp_rdata, 64'hDEAD_BEEF);
    chk_eq("spur_busy", busy, 0);
    step();
    chk_eq("spur_valid2", rsp_valid, 0);

    // backpressure write: rr_ptr=3 so requester 0 wins over 1; others keep requesting
    run_txn(4'b0011, 0, 1'b1, 32'h2000_0040, 64'hCAFE_F00D_1234_5678, 5, 1, 64'h0BAD, 4'b0011);
    // rr_ptr=1: requester 3 wins over 0
    run_txn(4'b1001, 3, 1'b0, 32'h0000_3FC0, 64'h0, 0, 3, 64'h0123_4567_89AB_CDEF, 4'b0000);
    // rr_ptr wrapped to 0
    run_txn(4'b1001, 0, 1'b1, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 64'h77, 4'b0000);

    // fairness: all requesting from reset, cache accepts at once and answers next cycle
    do_reset();
    exp_q = {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    req_valid = 4'hF;
    pend = 1'b0;
    last_rd = '0;
    ncyc = 0;
    while (exp_q.size() > 0 && ncyc < 60) begin
      if (rsp_valid != 0) begin
        e = exp_q.pop_front();
        chk_eq("fair_grant", rsp_valid, e);
        chk_eq("fair_data", rsp_rdata, last_rd);
      end
      c_rsp_valid = pend;
      c_rsp_rdata = 64'h1000 + 64'(ncyc);
      if (pend) last_rd = c_rsp_rdata;
      pend = c_req_valid;
      c_req_ready = c_req_valid;
      step();
      ncyc++;
    end
    chk_eq("fair_left", exp_q.size(), 0);
    do_reset();

    // reset in WAIT drops the transaction; late response is ignored
    run_txn(4'b0010, 1, 1'b0, 32'h400, 64'h0, 0, 1, 64'h99, 4'b0000);
    req_we[3] = 1'b1;
    req_addr[3*ADDR_W +: ADDR_W] = 32'h0000_0800;
    req_valid = 4'b1000;
    step();
    req_valid = '0;
    c_req_ready = 1'b1;
    step();
    c_req_ready = 1'b0;
    chk_eq("rw_busy", busy, 1);
    chk_eq("rw_grant", grant_id, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_eq("rw_busy0", busy, 0);
    chk_eq("rw_grant0", grant_id, 0);
    chk_eq("rw_c_valid", c_req_valid, 0);
    chk_eq("rw_c_addr", c_req_addr, 0);
    chk_eq("rw_c_we", c_req_we, 0);
    chk_eq("rw_rdata", rsp_rdata, 0);
    step();
    step();
    c_rsp_valid = 1'b1;
    c_rsp_rdata = 64'hBEEF;
    step();
    c_rsp_valid = 1'b0;
    chk_eq("rw_late_valid", rsp_valid, 0);
    chk_eq("rw_late_rdata", rsp_rdata, 0);
    chk_eq("rw_late_busy", busy, 0);
    run_txn(4'b1111, 0, 1'b0, 32'h500, 64'h0, 0, 1, 64'h5A5A, 4'b0000);

`ifdef CACHE_ARB_TIMEOUT_EN
    // watchdog: requester 1, accepted at once, no response
    req_we[1] = 1'b0;
    req_addr[1*ADDR_W +: ADDR_W] = 32'h300;
    req_valid = 4'b0010;
    #1;
    chk_eq("to_ready", req_ready, 4'b0010);
    step();
    req_valid = '0;
    c_req_ready = 1'b1;
    step();
    c_req_ready = 1'b0;
    for (int i = 1; i < TO_CYC; i++) step();
    chk_eq("to_pre_valid", rsp_valid, 0);
    chk_eq("to_pre_err", timeout_err, 0);
    chk_eq("to_pre_busy", busy, 1);
    step();
    chk_eq("to_valid", rsp_valid, 4'b0010);
    chk_eq("to_rdata", rsp_rdata, 0);
    chk_eq("to_err", timeout_err, 1);
    chk_eq("to_busy", busy, 0);
    run_txn(4'b0100, 2, 1'b1, 32'h340, 64'h42, 0, 2, 64'h1234, 4'b0000);
    chk_eq("to_sticky", timeout_err, 1);
`else
    chk_eq("no_tmo", timeout_err, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
